// File: rtl/calc_input_ctrl.sv
// calc_input_ctrl: button front-end for the 4-bit calculator.
// Three raw buttons are synchronised, debounced and turned into one-cycle
// press pulses; an entry FSM walks the user through operand A, operand B
// and the operator, then shows the result. A free-running divider steps
// the FND digit-scan select. o_field is the FSM state itself.
`timescale 1ns/1ps

module calc_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SCAN_DIV        = 100_000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_btn_inc,
    input  logic       i_btn_next,
    input  logic       i_btn_clear,
    output logic [3:0] o_a,
    output logic [3:0] o_b,
    output logic [1:0] o_selOperator,
    output logic [1:0] o_field,
    output logic       o_en,
    output logic [1:0] o_digitSelect
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int SC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    // The run that flips the stable level starts on the cycle the counter
    // is cleared by a fresh sample change, so the flip fires when the count
    // would step to DEBOUNCE_CYCLES-1, i.e. while it still holds D-2.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

    // Button bit order everywhere: [0]=inc, [1]=next, [2]=clear.
    localparam int BTN_INC   = 0;
    localparam int BTN_NEXT  = 1;
    localparam int BTN_CLEAR = 2;

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        ENTER_OP = 2'd2,
        SHOW     = 2'd3
    } field_t;

    logic [2:0]            btn_raw;
    logic [2:0]            sync_0;
    logic [2:0]            sync_1;
    logic [2:0]            sync_prev;
    logic [2:0]            stable;
    logic [2:0]            press;
    logic [2:0][DB_W-1:0]  db_cnt;
    logic [SC_W-1:0]       scan_cnt;
    field_t                state;

    assign btn_raw = {i_btn_clear, i_btn_next, i_btn_inc};
    assign o_field = state;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_0 <= '0;
            sync_1 <= '0;
        end else begin
            sync_0 <= btn_raw;
            sync_1 <= sync_0;
        end
    end

    // Debounce each synchronised level and emit a pulse on accepted 0->1.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_prev <= '0;
            stable    <= '0;
            press     <= '0;
            db_cnt    <= '0;
        end else begin
            sync_prev <= sync_1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync_1[i] == stable[i] || sync_1[i] != sync_prev[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync_1[i];
                    press[i]  <= sync_1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Entry FSM: clear wins; otherwise inc edits the current field and next
    // advances, both on the same edge when they coincide.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= ENTER_A;
            o_a           <= '0;
            o_b           <= '0;
            o_selOperator <= '0;
            o_en          <= 1'b0;
        end else if (press[BTN_CLEAR]) begin
            state         <= ENTER_A;
            o_a           <= '0;
            o_b           <= '0;
            o_selOperator <= '0;
            o_en          <= 1'b0;
        end else begin
            if (press[BTN_INC]) begin
                case (state)
                    ENTER_A:  o_a           <= o_a + 4'd1;
                    ENTER_B:  o_b           <= o_b + 4'd1;
                    ENTER_OP: o_selOperator <= o_selOperator + 2'd1;
                    default:  ;
                endcase
            end
            if (press[BTN_NEXT]) begin
                case (state)
                    ENTER_A:  state <= ENTER_B;
                    ENTER_B:  state <= ENTER_OP;
                    ENTER_OP: state <= SHOW;
                    default:  state <= ENTER_A;
                endcase
                o_en <= (state == ENTER_OP);
            end
        end
    end

    // Free-running digit-scan divider, independent of the entry FSM.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            scan_cnt      <= '0;
            o_digitSelect <= '0;
        end else if (scan_cnt == SC_LAST) begin
            scan_cnt      <= '0;
            o_digitSelect <= o_digitSelect + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Testbench for calc_input_ctrl: directed button sequences, a behavioural
// model (sample-window debounce, fixed pulse latency, arithmetic entry
// rules) checked every cycle, plus literal expectations from hand math.
`timescale 1ns/1ps

module tb_calc_input_ctrl;

    localparam int DB = 4;
    localparam int SD = 3;

    // ---------------- clock / reset ----------------
    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic btn_inc   = 1'b0;
    logic btn_next  = 1'b0;
    logic btn_clear = 1'b0;
    logic [3:0] o_a;
    logic [3:0] o_b;
    logic [1:0] o_sel;
    logic [1:0] o_field;
    logic       o_en;
    logic [1:0] o_digit;

    always #5 clk = ~clk;

    calc_input_ctrl #(.DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_btn_inc     (btn_inc),
        .i_btn_next    (btn_next),
        .i_btn_clear   (btn_clear),
        .o_a           (o_a),
        .o_b           (o_b),
        .o_selOperator (o_sel),
        .o_field       (o_field),
        .o_en          (o_en),
        .o_digitSelect (o_digit)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A button level is accepted once the last DB raw samples all disagree
    // with the accepted level. Two synchroniser stages plus the pulse
    // register put the resulting register update 3 edges after that sample.
    int         m_a     = 0;
    int         m_b     = 0;
    int         m_op    = 0;
    int         m_field = 0;
    int         m_edges = 0;
    bit [DB-1:0] hist [3];
    bit          m_stable [3];
    bit [2:0]    pipe [3];
    bit [2:0]    raw_s;
    bit [2:0]    det;
    bit [2:0]    ev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_op = 0; m_field = 0; m_edges = 0;
            for (int i = 0; i < 3; i++) begin
                hist[i] = '0;
                m_stable[i] = 1'b0;
                pipe[i] = '0;
            end
        end else begin
            raw_s = {btn_clear, btn_next, btn_inc};
            ev = pipe[2];
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            det = '0;
            for (int i = 0; i < 3; i++) begin
                hist[i] = {hist[i][DB-2:0], raw_s[i]};
                if (!m_stable[i] && hist[i] == '1) begin
                    m_stable[i] = 1'b1;
                    det[i] = 1'b1;
                end else if (m_stable[i] && hist[i] == '0) begin
                    m_stable[i] = 1'b0;
                end
            end
            pipe[0] = det;
            m_edges++;
            if (ev[2]) begin
                m_a = 0; m_b = 0; m_op = 0; m_field = 0;
            end else begin
                if (ev[0]) begin
                    if (m_field == 0) m_a = (m_a + 1) % 16;
                    else if (m_field == 1) m_b = (m_b + 1) % 16;
                    else if (m_field == 2) m_op = (m_op + 1) % 4;
                end
                if (ev[1]) m_field = (m_field + 1) % 4;
            end
        end
    end

    // Compare process: every cycle out of reset, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_a", o_a, m_a);
            check("model_b", o_b, m_b);
            check("model_op", o_sel, m_op);
            check("model_field", o_field, m_field);
            check("model_en", o_en, (m_field == 3) ? 1 : 0);
            check("model_digit", o_digit, (m_edges / SD) % 4);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold a button mask long enough to qualify, then release long enough
    // for both the update and the release to settle.
    task automatic press(input logic [2:0] mask);
        @(negedge clk);
        {btn_clear, btn_next, btn_inc} = mask;
        cycles(DB + 2);
        {btn_clear, btn_next, btn_inc} = 3'b000;
        cycles(DB + 2);
    endtask

    task automatic check_all(input string tag, input int a, input int b, input int op,
                             input int fld, input int en);
        check({tag, "_a"}, o_a, a);
        check({tag, "_b"}, o_b, b);
        check({tag, "_op"}, o_sel, op);
        check({tag, "_field"}, o_field, fld);
        check({tag, "_en"}, o_en, en);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    int scan_exp [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

    initial begin
        rst_n = 1'b0;
        cycles(3);
        check_all("reset", 0, 0, 0, 0, 0);
        check("reset_digit", o_digit, 0);

        // Reset release and scan cadence.
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check("scan_step", o_digit, scan_exp[n]);
            check("scan_en", o_en, 0);
        end
        check_all("idle", 0, 0, 0, 0, 0);

        // 3-clock glitch is rejected.
        @(negedge clk);
        btn_inc = 1'b1;
        cycles(3);
        btn_inc = 1'b0;
        cycles(8);
        check("glitch_a", o_a, 0);

        // Latency: high before edge k, o_a=1 visible after edge k+6, once.
        @(negedge clk);
        btn_inc = 1'b1;
        cycles(6);
        check("lat_before", o_a, 0);
        cycles(1);
        check("lat_after", o_a, 1);
        cycles(3);
        btn_inc = 1'b0;
        cycles(8);
        check("lat_once", o_a, 1);

        press(3'b100);
        check_all("clear1", 0, 0, 0, 0, 0);

        // Full entry sequence.
        repeat (5) press(3'b001);
        press(3'b010);
        repeat (3) press(3'b001);
        press(3'b010);
        repeat (2) press(3'b001);
        press(3'b010);
        check_all("entry", 5, 3, 2, 3, 1);
        press(3'b001);
        check_all("show_inc", 5, 3, 2, 3, 1);
        press(3'b010);
        check_all("wrap_field", 5, 3, 2, 0, 0);

        // Value wrap.
        press(3'b100);
        repeat (17) press(3'b001);
        check("wrap_a", o_a, 1);
        press(3'b010);
        press(3'b010);
        repeat (5) press(3'b001);
        check("wrap_op", o_sel, 1);
        check("wrap_op_field", o_field, 2);

        // Simultaneous inc+next, then clear+inc.
        press(3'b100);
        press(3'b001);
        press(3'b001);
        check("pre_sim_a", o_a, 2);
        press(3'b011);
        check("sim_a", o_a, 3);
        check("sim_field", o_field, 1);
        press(3'b001);
        check("sim_b", o_b, 1);
        press(3'b101);
        check_all("clr_inc", 0, 0, 0, 0, 0);

        // Asynchronous reset in SHOW.
        repeat (7) press(3'b001);
        repeat (3) press(3'b010);
        check_all("pre_rst", 7, 0, 0, 3, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0);
        check("async_rst_digit", o_digit, 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(10);
        check("post_rst_a", o_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
